// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampled serial frames into a 1-entry valid/ready holding register.
// Optional parity bit when UART_RX_PARITY_EN is defined (PARITY_ODD selects odd/even).
module uart_rx #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW           = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 good_c, ferr_c;
  logic                 good_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt, perr_c;
`endif

  // Next-state, sampling counters and frame result strobes
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    good_c      = 1'b0;
    ferr_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_c      = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_nxt = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx, shreg[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt + BW'(1);
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
          if (((^shreg) ^ rx) != PARITY_ODD) begin
            perr_c      = 1'b1;
            par_bad_nxt = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          // A parity failure already reported this frame suppresses further pulses
          if (rx) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            good_c    = !par_bad;
`else
            good_c    = 1'b1;
`endif
          end else begin
            state_nxt = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
            ferr_c    = !par_bad;
`else
            ferr_c    = 1'b1;
`endif
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Receive FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      good_q    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      good_q    <= good_c;
      frame_err <= ferr_c;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= perr_c;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Holding register: loads one cycle after a good stop bit, drops the new byte if still full
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (good_q) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; parity cases build only with UART_RX_PARITY_EN.
module tb_uart_rx;
  localparam int unsigned CLK_HZ    = 1_600_000;
  localparam int unsigned BAUD      = 100_000;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned CPB       = 16;
  localparam bit          P_ODD     = 1'b0;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic       valid, busy, frame_err, parity_err, overrun;
  logic [7:0] data;

  int n_checks = 0;
  int n_err    = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  int n_ovr    = 0;
  logic [7:0] acc[$];
  int b_valid, b_ferr, b_perr, b_ovr, b_acc;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS),
    .PARITY_ODD(P_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  // Cycle counts of outputs and accepted bytes, sampled mid-cycle
  always @(negedge clk) begin
    if (valid) n_valid++;
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (overrun) n_ovr++;
    if (valid && ready) acc.push_back(data);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    b_valid = n_valid;
    b_ferr  = n_ferr;
    b_perr  = n_perr;
    b_ovr   = n_ovr;
    b_acc   = acc.size();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // Start bit, payload LSB first, and the parity bit when enabled (flip=1 corrupts it)
  task automatic send_body(input logic [7:0] d, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ P_ODD ^ flip);
`else
    if (flip) rx = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    send_body(d, flip);
    send_bit(stop);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] acc_at(input int idx);
    logic [7:0] v;
    v = 8'hxx;
    if (idx < acc.size()) v = acc[idx];
    return v;
  endfunction

  initial begin
    int polls;
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_pulses", 32'({frame_err, parity_err, overrun}), 32'd0);
    rst = 1'b0;
    tick(2);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Clean frame with consumer always ready
    ready = 1'b1;
    mark();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(4);
    check("a5_valid_cycles", 32'(n_valid - b_valid), 32'd1);
    check("a5_accepted", 32'(acc.size() - b_acc), 32'd1);
    check("a5_data", 32'(acc_at(b_acc)), 32'hA5);
    check("a5_pulses", 32'((n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr)), 32'd0);
    check("a5_busy", 32'(busy), 32'd0);

    // Short low glitch is rejected at the start-bit sample
    mark();
    rx = 1'b0;
    tick(2);
    check("glitch_busy_mid", 32'(busy), 32'd1);
    tick(2);
    rx = 1'b1;
    tick(8);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_valid", 32'(n_valid - b_valid), 32'd0);
    check("glitch_pulses", 32'((n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr)), 32'd0);

    // Stop bit low followed by a held-low line
    mark();
    send_body(8'h3C, 1'b0);
    send_bit(1'b0);
    tick(40);
    check("ferr_busy_low", 32'(busy), 32'd1);
    check("ferr_pulse", 32'(n_ferr - b_ferr), 32'd1);
    check("ferr_valid", 32'(n_valid - b_valid), 32'd0);
    check("ferr_perr", 32'(n_perr - b_perr), 32'd0);
    rx = 1'b1;
    tick(3);
    check("ferr_busy_high", 32'(busy), 32'd0);

    // Back-to-back frames with consumer stalled
    ready = 1'b0;
    mark();
    send_frame(8'h11, 1'b1, 1'b0);
    tick(4);
    check("b2b_valid1", 32'(valid), 32'd1);
    check("b2b_data1", 32'(data), 32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(4);
    check("b2b_overrun", 32'(n_ovr - b_ovr), 32'd1);
    check("b2b_data_kept", 32'(data), 32'h11);
    check("b2b_valid_kept", 32'(valid), 32'd1);
    check("b2b_ferr", 32'(n_ferr - b_ferr), 32'd0);

    // Drain, then accept in the same cycle a new byte loads
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);
    check("drain_valid", 32'(valid), 32'd0);
    mark();
    send_frame(8'h33, 1'b1, 1'b0);
    tick(4);
    check("x33_data", 32'(data), 32'h33);
    send_body(8'h44, 1'b0);
    rx = 1'b1;
    polls = 0;
    while (busy && polls < 20) begin
      tick(1);
      polls++;
    end
    check("x44_stop_seen", 32'(busy), 32'd0);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("x44_valid", 32'(valid), 32'd1);
    check("x44_data", 32'(data), 32'h44);
    check("x44_overrun", 32'(n_ovr - b_ovr), 32'd0);
    check("x44_accepted", 32'(acc.size() - b_acc), 32'd1);
    check("x44_acc_data", 32'(acc_at(b_acc)), 32'h33);
    tick(12);

    // Reset after the third data bit, with a byte still held
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(data), 32'h00);
    tick(20);
    check("midrst_idle", 32'(busy), 32'd0);
    mark();
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(4);
    check("x7e_valid", 32'(valid), 32'd1);
    check("x7e_data", 32'(data), 32'h7E);
    check("x7e_pulses", 32'((n_ferr - b_ferr) + (n_perr - b_perr) + (n_ovr - b_ovr)), 32'd0);

`ifdef UART_RX_PARITY_EN
    ready = 1'b1;
    tick(2);
    mark();
    send_frame(8'h01, 1'b1, 1'b1);
    tick(4);
    check("par_bad_perr", 32'(n_perr - b_perr), 32'd1);
    check("par_bad_valid", 32'(n_valid - b_valid), 32'd0);
    check("par_bad_ferr", 32'(n_ferr - b_ferr), 32'd0);
    mark();
    send_frame(8'h01, 1'b1, 1'b0);
    tick(4);
    check("par_ok_accepted", 32'(acc.size() - b_acc), 32'd1);
    check("par_ok_data", 32'(acc_at(b_acc)), 32'h01);
    check("par_ok_perr", 32'(n_perr - b_perr), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
